// File: rtl/ysyx_25070198_pkg.sv
// Shared LSU types: FSM state encoding, bus request payload and timeout default.
package ysyx_25070198_pkg;

  localparam int unsigned LSU_TIMEOUT = 255;
  localparam int unsigned BUS_ADDR_W  = 32;
  localparam int unsigned BUS_DATA_W  = 32;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  wen;
    logic [1:0]            size;
    logic [3:0]            wmask;
    logic [BUS_DATA_W-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/ysyx_25070198_lsu.sv
// Load/store unit: one outstanding bus access per instruction, held in DONE until retire.
module ysyx_25070198_lsu
  import ysyx_25070198_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [29:0] mem_addr,
  input  logic [1:0]  sel,
  input  logic [1:0]  io_lsu_size,
  input  logic [3:0]  mem_mask,
  input  logic [31:0] mem_wdata,
  input  logic        inst_done,
  output logic        io_lsu_respValid,
  output logic [31:0] mem_rdata,
  output logic        lsu_err,
  output logic        bus_reqValid,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_wdata,
  input  logic        bus_reqReady,
  input  logic        bus_respValid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_t     state, next_state;
  lsu_req_t       req_q, req_in, bus_q, bus_d;
  logic [CNT_W-1:0] cnt_q;
  logic           capture, handshake, resp_hit, timeout;
  logic           bus_valid_d, resp_d, err_d;
  logic [31:0]    rdata_d;

  // Request decode; a simultaneous load and store resolves to the load.
  always_comb begin
    req_in       = '0;
    req_in.addr  = {mem_addr, sel};
    req_in.wen   = mem_wen & ~mem_ren;
    req_in.size  = io_lsu_size;
    req_in.wmask = mem_mask;
    req_in.wdata = mem_wdata;
    capture      = (state == LSU_IDLE) && (mem_ren || mem_wen);
    handshake    = (state == LSU_REQ) && bus_reqValid && bus_reqReady;
    resp_hit     = (state == LSU_WAIT) && bus_respValid;
    timeout      = (state == LSU_WAIT) && !bus_respValid &&
                   (CNT_W'(cnt_q + 1'b1) == CNT_W'(TIMEOUT));
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= LSU_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      LSU_IDLE: if (capture)              next_state = LSU_REQ;
      LSU_REQ:  if (handshake)            next_state = LSU_WAIT;
      LSU_WAIT: if (resp_hit || timeout)  next_state = LSU_DONE;
      LSU_DONE: if (inst_done)            next_state = LSU_IDLE;
      default:                            next_state = LSU_IDLE;
    endcase
  end

  // Output next-values; bus payload is zero whenever the next state is not REQ.
  always_comb begin
    bus_valid_d = (next_state == LSU_REQ);
    bus_d       = '0;
    if (next_state == LSU_REQ) bus_d = capture ? req_in : req_q;
    resp_d      = resp_hit || timeout;
    err_d       = timeout;
    rdata_d     = mem_rdata;
    if (resp_hit && !req_q.wen) rdata_d = bus_rdata;
    else if (timeout)           rdata_d = '0;
  end

  // Request registers, WAIT counter and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q            <= '0;
      cnt_q            <= '0;
      bus_q            <= '0;
      bus_reqValid     <= 1'b0;
      io_lsu_respValid <= 1'b0;
      lsu_err          <= 1'b0;
      mem_rdata        <= '0;
    end else begin
      if (capture) req_q <= req_in;
      if (handshake)                                 cnt_q <= '0;
      else if (state == LSU_WAIT && !bus_respValid)  cnt_q <= CNT_W'(cnt_q + 1'b1);
      bus_q            <= bus_d;
      bus_reqValid     <= bus_valid_d;
      io_lsu_respValid <= resp_d;
      lsu_err          <= err_d;
      mem_rdata        <= rdata_d;
    end
  end

  assign bus_addr  = bus_q.addr;
  assign bus_wen   = bus_q.wen;
  assign bus_size  = bus_q.size;
  assign bus_wmask = bus_q.wmask;
  assign bus_wdata = bus_q.wdata;

endmodule

// File: doc/ysyx_25070198_lsu.md
YSYX_25070198_LSU -- requirements
Module: ysyx_25070198_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before the access is forced complete.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have ports mem_ren and mem_wen, input, 1 each, load and store requests from the execute stage.
REQ-005 SHALL have port mem_addr, input, 30, the word address.
REQ-006 SHALL have port sel, input, 2, the byte offset within the word.
REQ-007 SHALL have port io_lsu_size, input, 2, access size (00 byte, 10 word).
REQ-008 SHALL have ports mem_mask (input, 4) and mem_wdata (input, 32), the store byte-enables and the lane-aligned store data.
REQ-009 SHALL have port inst_done, input, 1, the instruction-retire pulse.
REQ-010 SHALL have port io_lsu_respValid, output, 1, the access-complete pulse to execute and the register file.
REQ-011 SHALL have port mem_rdata, output, 32, the raw load word (byte extraction is done downstream).
REQ-012 SHALL have port lsu_err, output, 1, a timeout pulse.
REQ-013 SHALL have bus request outputs: bus_reqValid (1), bus_addr (32), bus_wen (1), bus_size (2), bus_wmask (4), bus_wdata (32).
REQ-014 SHALL have bus inputs bus_reqReady (1), bus_respValid (1) and bus_rdata (32).

Function
REQ-015 SHALL implement a 4-state FSM with states IDLE, REQ, WAIT and DONE.
REQ-016 IDLE: on (mem_ren | mem_wen), SHALL capture addr, size, mask, wdata and wen into request registers and go to REQ.
REQ-017 A captured read SHALL set wen = 0; when mem_ren and mem_wen are both high, the read SHALL win and the store SHALL be dropped.
REQ-018 The captured bus address SHALL be {mem_addr, sel}.
REQ-019 REQ: bus_reqValid = 1 and the bus_* outputs SHALL come from the request registers, stable until a handshake.
REQ-020 REQ: on bus_reqValid & bus_reqReady the FSM SHALL go to WAIT, with the handshake taking effect in the same cycle.
REQ-021 WAIT: bus_reqValid = 0; on bus_respValid the FSM SHALL go to DONE, latching bus_rdata into mem_rdata for reads only.
REQ-022 Entry to DONE SHALL produce io_lsu_respValid high for exactly one cycle, the cycle after bus_respValid is sampled.
REQ-023 Latency SHALL be 1 cycle from request capture to bus_reqValid, and 1 cycle from bus_respValid to io_lsu_respValid.
REQ-024 DONE: the FSM SHALL return to IDLE only on inst_done; mem_ren/mem_wen re-asserting while in DONE SHALL be ignored (no duplicate access).
REQ-025 In IDLE, inst_done SHALL have no effect.
REQ-026 mem_rdata SHALL hold its value until the next read response and SHALL NOT change on stores.
REQ-027 WAIT counter: SHALL clear on WAIT entry and increment each WAIT cycle without bus_respValid.
REQ-028 Timeout: when the counter reaches TIMEOUT, the FSM SHALL go to DONE with mem_rdata = 0, and io_lsu_respValid and lsu_err SHALL pulse together for one cycle.
REQ-029 bus_respValid sampled in IDLE, REQ or DONE SHALL be ignored (covers stale responses after reset).
REQ-030 bus_reqValid SHALL never be asserted outside REQ.
REQ-031 In states other than REQ, the bus_* data outputs SHALL be 0.

Reset
REQ-032 reset low SHALL asynchronously force IDLE.
REQ-033 reset low SHALL clear the counter, mem_rdata, io_lsu_respValid, lsu_err, bus_reqValid and all request registers to 0.
REQ-034 Reset asserted mid-access (REQ or WAIT) SHALL abandon the access with no respValid pulse.
REQ-035 The first request SHALL be accepted no earlier than the first clock edge after reset deasserts.

Structure
REQ-036 The lsu_state_t enum and the LSU_TIMEOUT default SHALL live in shared package ysyx_25070198_pkg.
REQ-037 SHALL be a single module with no sub-module; the counter and request registers are inline.

Verification
REQ-038 Load word: mem_ren, mem_addr=0x0800_0001, sel=0, bus_reqReady=1, bus_rdata=0xDEADBEEF after 3 cycles -> bus_addr=0x2000_0004 once; respValid 1 cycle; mem_rdata=0xDEADBEEF.
REQ-039 Store byte: mem_wen, sel=2, mask=4'b0100, wdata=0x00AB0000 -> bus_wen=1, bus_wmask=0100, bus_size=00; mem_rdata unchanged.
REQ-040 Backpressure: bus_reqReady low 5 cycles -> bus_reqValid held and bus_addr stable for 5 cycles; exactly one handshake.
REQ-041 Re-request in DONE: mem_ren held high 4 cycles before inst_done -> no second bus_reqValid; after inst_done, next mem_ren starts a new access.
REQ-042 Timeout: bus_respValid never arrives -> after 255 WAIT cycles respValid=lsu_err=1 for 1 cycle, mem_rdata=0.
REQ-043 Reset in WAIT, then bus_respValid arrives after reset release -> no respValid pulse; FSM stays IDLE.
